// File: rtl/diff_pkg.sv
// Shared timing constants, frame geometry and transmitter state encoding for
// the pulse-width-coded link (diff_tx / diff_rx).
// Optional build macro: DIFF_TX_IDLE_GAP_EN adds the post-frame GAP state.
package diff_pkg;

    localparam int DATA_PERIOD               = 20;
    localparam int HALF_DATA_PERIOD          = DATA_PERIOD / 2;
    localparam int QUARTER_DATA_PERIOD       = DATA_PERIOD / 4;
    localparam int THREE_QUARTER_DATA_PERIOD = (3 * DATA_PERIOD) / 4;
    localparam int CODE_WIDTH                = 26;

    // Segment counter is sized for a whole data period so the GAP build fits too.
    localparam int CNT_W = $clog2(DATA_PERIOD + 1);
    localparam int IDX_W = $clog2(CODE_WIDTH);

    typedef logic [CNT_W-1:0] seg_len_t;

    typedef enum logic [2:0] {
        TX_IDLE = 3'd0,
        TX_SL   = 3'd1,
        TX_SH   = 3'd2,
        TX_DL   = 3'd3,
        TX_DH   = 3'd4,
        TX_EL   = 3'd5
`ifdef DIFF_TX_IDLE_GAP_EN
        ,
        TX_GAP  = 3'd6
`endif
    } tx_state_e;

    // Length in cycles of the segment driven while in state st carrying bit_v.
    // A '1' bit is long-low/short-high, a '0' bit short-low/long-high.
    function automatic seg_len_t seg_len(input tx_state_e st, input logic bit_v);
        seg_len_t len;
        case (st)
            TX_SL, TX_SH, TX_EL: len = seg_len_t'(HALF_DATA_PERIOD);
            TX_DL:   len = bit_v ? seg_len_t'(THREE_QUARTER_DATA_PERIOD)
                                 : seg_len_t'(QUARTER_DATA_PERIOD);
            TX_DH:   len = bit_v ? seg_len_t'(QUARTER_DATA_PERIOD)
                                 : seg_len_t'(THREE_QUARTER_DATA_PERIOD);
`ifdef DIFF_TX_IDLE_GAP_EN
            TX_GAP:  len = seg_len_t'(DATA_PERIOD);
`endif
            default: len = '0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/diff_tx_if.sv
// Code-source <-> transmitter bundle. The source (master) offers a code and a
// trigger; the transmitter (slave) returns handshake status and the line.
interface diff_tx_if;
    import diff_pkg::*;

    logic [CODE_WIDTH-1:0] code_in;
    logic                  trigger_in;
    logic                  ready_out;
    logic                  busy_out;
    logic                  data_out;
    logic                  done_out;

    modport master (
        output code_in,
        output trigger_in,
        input  ready_out,
        input  busy_out,
        input  data_out,
        input  done_out
    );

    modport slave (
        input  code_in,
        input  trigger_in,
        output ready_out,
        output busy_out,
        output data_out,
        output done_out
    );

endinterface

// File: rtl/diff_seg_timer.sv
// Segment timer: load starts a segment of len_i cycles (count 1..len_i);
// last_o marks the final cycle of the running segment. Count returns to 0
// when a segment ends without a new load, i.e. when the line goes idle.
module diff_seg_timer
    import diff_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     load_i,
    input  seg_len_t len_i,
    output logic     last_o
);

    seg_len_t cnt_q;
    seg_len_t cnt_d;
    seg_len_t len_q;
    seg_len_t len_d;

    assign last_o = (cnt_q != '0) && (cnt_q == len_q);

    // Next count: restart on load, stop at the end of a segment, else advance.
    always_comb begin
        cnt_d = cnt_q;
        len_d = len_q;
        if (load_i) begin
            cnt_d = seg_len_t'(1);
            len_d = len_i;
        end else if (last_o) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q + seg_len_t'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // Counter and latched segment length registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            len_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            len_q <= len_d;
        end
    end

endmodule

// File: rtl/diff_tx.sv
// diff_tx: pulse-width-coded serial transmitter. Sends sync-low, sync-high,
// CODE_WIDTH PWM bits MSB first, end-low, then returns the line high.
// Build macro DIFF_TX_IDLE_GAP_EN: hold the line high in a busy GAP state for
// one data period after each frame so the receiver can re-arm.
module diff_tx
    import diff_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    diff_tx_if.slave    tx_if
);

    tx_state_e             state_q;
    tx_state_e             state_d;
    logic [CODE_WIDTH-1:0] shift_q;
    logic [CODE_WIDTH-1:0] shift_d;
    logic [IDX_W-1:0]      bit_idx_q;
    logic [IDX_W-1:0]      bit_idx_d;

    logic data_q;
    logic data_d;
    logic busy_q;
    logic busy_d;
    logic ready_q;
    logic ready_d;
    logic done_q;
    logic done_d;

    logic     accept_s;
    logic     seg_last_s;
    logic     seg_load_s;
    seg_len_t seg_len_s;

    assign accept_s = tx_if.trigger_in && ready_q;

    diff_seg_timer u_seg_timer (
        .clk_i  (clk_in),
        .rst_i  (rst_in),
        .load_i (seg_load_s),
        .len_i  (seg_len_s),
        .last_o (seg_last_s)
    );

    // State, frame data and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            data_q    <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    // Next state: advance one segment each time the timer reports its last cycle.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            TX_IDLE: begin
                if (accept_s) begin
                    state_d   = TX_SL;
                    shift_d   = tx_if.code_in;
                    bit_idx_d = IDX_W'(CODE_WIDTH - 1);
                end else begin
                    state_d = TX_IDLE;
                end
            end
            TX_SL: state_d = seg_last_s ? TX_SH : TX_SL;
            TX_SH: state_d = seg_last_s ? TX_DL : TX_SH;
            TX_DL: state_d = seg_last_s ? TX_DH : TX_DL;
            TX_DH: begin
                if (seg_last_s && (bit_idx_q != '0)) begin
                    state_d   = TX_DL;
                    bit_idx_d = bit_idx_q - IDX_W'(1);
                end else if (seg_last_s) begin
                    state_d = TX_EL;
                end else begin
                    state_d = TX_DH;
                end
            end
            TX_EL: begin
                if (seg_last_s) begin
`ifdef DIFF_TX_IDLE_GAP_EN
                    state_d = TX_GAP;
`else
                    state_d = TX_IDLE;
`endif
                end else begin
                    state_d = TX_EL;
                end
            end
`ifdef DIFF_TX_IDLE_GAP_EN
            TX_GAP: state_d = seg_last_s ? TX_IDLE : TX_GAP;
`endif
            default: state_d = TX_IDLE;
        endcase
    end

    // Outputs follow the state being entered so they change on the same edge;
    // every state change other than into IDLE starts a fresh segment.
    always_comb begin
        data_d     = ((state_d == TX_SL) || (state_d == TX_DL) || (state_d == TX_EL)) ? 1'b0 : 1'b1;
        busy_d     = (state_d != TX_IDLE);
        ready_d    = (state_d == TX_IDLE);
        done_d     = (state_q == TX_EL) && (state_d != TX_EL);
        seg_load_s = (state_d != state_q) && (state_d != TX_IDLE);
        seg_len_s  = seg_len(state_d, shift_d[bit_idx_d]);
    end

    assign tx_if.data_out  = data_q;
    assign tx_if.busy_out  = busy_q;
    assign tx_if.ready_out = ready_q;
    assign tx_if.done_out  = done_q;

endmodule

// File: tb/tb_diff_tx.sv
// Directed bench for diff_tx: expected line waveform is built from the code
// independently, and a small pulse-width decoder stands in for diff_rx.
module tb_diff_tx;
    import diff_pkg::*;

`ifdef DIFF_TX_IDLE_GAP_EN
    localparam int GAP_EN = 1;
`else
    localparam int GAP_EN = 0;
`endif
    localparam int FRAME_K = 551;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   checks = 0;
    int   errors = 0;

    diff_tx_if tx_bus ();

    diff_tx dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .tx_if  (tx_bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected line level at cycle k (k=1 is the first low cycle).
    function automatic logic exp_level(input logic [25:0] code, input int k);
        int b;
        int off;
        if (k <= 10) return 1'b0;
        if (k <= 20) return 1'b1;
        if (k <= 540) begin
            b   = (k - 21) / 20;
            off = (k - 21) % 20;
            return (off < (code[25-b] ? 15 : 5)) ? 1'b0 : 1'b1;
        end
        if (k <= 550) return 1'b0;
        return 1'b1;
    endfunction

    // Waits for the frame start (checking the high gap before it), then checks
    // every cycle of the frame and decodes it from the low-pulse widths.
    task automatic check_frame(input logic [25:0] code, input int exp_gap,
                               input int poke_k, input logic [25:0] poke_code);
        int w = 0;
        int bad_data = 0, bad_busy = 0, bad_ready = 0, bad_done = 0;
        int run = 0, nruns = 0;
        logic [25:0] dec = '0;
        while (tx_bus.data_out !== 1'b0 && w < 100) begin
            @(negedge clk_in);
            w++;
        end
        chk("frame_start", {31'd0, tx_bus.data_out}, 32'd0);
        if (tx_bus.data_out !== 1'b0) return;
        if (exp_gap >= 0) chk("gap_cycles", w, exp_gap);
        for (int k = 1; k <= FRAME_K; k++) begin
            if (tx_bus.data_out !== exp_level(code, k)) bad_data++;
            if (tx_bus.busy_out !== ((k <= 550) ? 1'b1 : (GAP_EN == 1))) bad_busy++;
            if (tx_bus.ready_out !== ((k <= 550) ? 1'b0 : (GAP_EN == 0))) bad_ready++;
            if (tx_bus.done_out !== (k == FRAME_K)) bad_done++;
            if (tx_bus.data_out === 1'b0) run++;
            else if (run > 0) begin
                if (nruns >= 1 && nruns <= 26) dec = {dec[24:0], (run > 10)};
                nruns++;
                run = 0;
            end
            if (k == poke_k) begin
                tx_bus.trigger_in = 1'b1;
                tx_bus.code_in    = poke_code;
            end else if (k == poke_k + 1) begin
                tx_bus.trigger_in = 1'b0;
            end
            if (k < FRAME_K) @(negedge clk_in);
        end
        chk("frame_data", bad_data, 0);
        chk("frame_busy", bad_busy, 0);
        chk("frame_ready", bad_ready, 0);
        chk("frame_done", bad_done, 0);
        chk("rx_pulses", nruns, 28);
        chk("rx_code", {6'd0, dec}, {6'd0, code});
    endtask

    task automatic send_one(input logic [25:0] code);
        tx_bus.code_in    = code;
        tx_bus.trigger_in = 1'b1;
        @(negedge clk_in);
        tx_bus.trigger_in = 1'b0;
        check_frame(code, 0, -10, 26'd0);
    endtask

    task automatic idle_check(input string tag, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            if (tx_bus.data_out !== 1'b1 || tx_bus.ready_out !== 1'b1 ||
                tx_bus.busy_out !== 1'b0 || tx_bus.done_out !== 1'b0) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        tx_bus.code_in    = '0;
        tx_bus.trigger_in = 1'b0;

        // Reset state.
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        chk("rst_data", {31'd0, tx_bus.data_out}, 32'd1);
        chk("rst_ready", {31'd0, tx_bus.ready_out}, 32'd1);
        chk("rst_busy", {31'd0, tx_bus.busy_out}, 32'd0);
        chk("rst_done", {31'd0, tx_bus.done_out}, 32'd0);
        idle_check("idle_100", 100);

        // Alternating pattern, MSB=1 first.
        send_one(26'h2AAAAAA);
        idle_check("idle_after_2aa", 5);

        // Loopback codes.
        send_one(26'h0000000);
        idle_check("idle_after_0", 3);
        send_one(26'h3FFFFFF);
        idle_check("idle_after_3ff", 3);
        send_one(26'h1234567);
        idle_check("idle_after_123", 3);

        // Trigger with another code mid-frame is ignored.
        tx_bus.code_in    = 26'h0ABCDEF;
        tx_bus.trigger_in = 1'b1;
        @(negedge clk_in);
        tx_bus.trigger_in = 1'b0;
        check_frame(26'h0ABCDEF, 0, 100, 26'h3543210);
        idle_check("no_queued_frame", 30);

        // Trigger held high: back-to-back frames.
        tx_bus.code_in    = 26'h1C3A5F0;
        tx_bus.trigger_in = 1'b1;
        @(negedge clk_in);
        check_frame(26'h1C3A5F0, 0, -10, 26'd0);
        check_frame(26'h1C3A5F0, (GAP_EN == 1) ? 21 : 1, -10, 26'd0);
        check_frame(26'h1C3A5F0, (GAP_EN == 1) ? 21 : 1, -10, 26'd0);
        tx_bus.trigger_in = 1'b0;
        repeat (25) @(negedge clk_in);
        idle_check("idle_after_held", 5);

        // Reset during sync-high.
        tx_bus.code_in    = 26'h0F0F0F0;
        tx_bus.trigger_in = 1'b1;
        @(negedge clk_in);
        tx_bus.trigger_in = 1'b0;
        chk("accept_low", {31'd0, tx_bus.data_out}, 32'd0);
        chk("accept_busy", {31'd0, tx_bus.busy_out}, 32'd1);
        repeat (14) @(negedge clk_in);
        chk("sh_high", {31'd0, tx_bus.data_out}, 32'd1);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("rst_sh_data", {31'd0, tx_bus.data_out}, 32'd1);
        chk("rst_sh_ready", {31'd0, tx_bus.ready_out}, 32'd1);
        chk("rst_sh_busy", {31'd0, tx_bus.busy_out}, 32'd0);
        idle_check("idle_after_rst_sh", 30);

        // Reset during a long data-low pulse.
        tx_bus.code_in    = 26'h3000000;
        tx_bus.trigger_in = 1'b1;
        @(negedge clk_in);
        tx_bus.trigger_in = 1'b0;
        repeat (29) @(negedge clk_in);
        chk("dl_low", {31'd0, tx_bus.data_out}, 32'd0);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        chk("rst_dl_data", {31'd0, tx_bus.data_out}, 32'd1);
        chk("rst_dl_done", {31'd0, tx_bus.done_out}, 32'd0);
        idle_check("idle_after_rst_dl", 30);

        // Recovery frame after the aborted ones.
        send_one(26'h1555555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
